modn_digit_counter: RTL
=======================

# modn_digit_counter

Parametrised modulo-N digit counter for the watch controller, generalising the fixed mod-2 stage to any modulus. It holds one time digit (seconds units, tens, minutes, hours…), advances on a carry-in from the lower digit while running, and emits a same-cycle carry-out for chaining. It adds a run/stop/clear state machine, parallel load for time setting, and optional down-counting for timer mode.

## Interface
- MODULUS, 10, count modulus N; legal range 2..2**WIDTH
- WIDTH, 4, width of number/load_value
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- start_resume  in  1  request RUN from IDLE/HOLD (level, sampled per cycle)
- stop  in  1  request HOLD from RUN
- clear  in  1  synchronous clear to 0, go IDLE
- load  in  1  parallel load strobe (honoured in IDLE/HOLD only)
- load_value  in  WIDTH  value to load
- cin  in  1  count enable / carry from lower digit (tie 1 for the lowest digit)
- down  in  1  count direction, 1 = decrement (present only with MODN_COUNTER_DOWN_EN)
- number  out  WIDTH  current digit value, registered
- cout  out  1  carry/borrow to next digit, combinational
- running  out  1  high while state is RUN, registered

## Operation
- States: IDLE (reset/cleared), RUN, HOLD (paused, value retained).
- Per-cycle priority: clear > load > stop > start_resume > count.
- clear=1: number←0, state←IDLE, from any state.
- load=1 in IDLE/HOLD: number←load_value; if load_value ≥ MODULUS, number←MODULUS-1. State unchanged. Ignored in RUN.
- stop=1 in RUN: state←HOLD; no count that cycle.
- start_resume=1 in IDLE/HOLD: state←RUN; counting begins next cycle.
- stop and start_resume both high: stop wins (RUN→HOLD; IDLE/HOLD unchanged).
- Count: in RUN with cin=1 and no higher-priority event, number←number+1, wrapping MODULUS-1→0.
- cout = (state==RUN) & cin & (number==MODULUS-1) & ~stop & ~clear; it marks the wrap cycle exactly.
- number never leaves 0..MODULUS-1; any out-of-range value is forced to 0 on the next clock.
- Arithmetic is done at WIDTH+1 bits internally so MODULUS = 2**WIDTH wraps correctly.

## Timing
- Reset (reset=0, asynchronous): number=0, running=0, state=IDLE, cout=0 immediately. Release is synchronised by the caller.
- number, running: one clock latency from the controlling input.
- cout: zero latency, combinational from state, cin, number, stop, clear. Chained digits ripple in the same cycle, and all digits update on the same edge.
- Reset asserted mid-count: value lost and outputs return to reset values without waiting for clk.
- One count per clock at most. With cin held high, the full period is MODULUS cycles.

## Configuration
- MODN_COUNTER_DOWN_EN defined: `down` port exists. With down=1 in RUN and cin=1, number←number-1, wrapping 0→MODULUS-1. cout then becomes a borrow: asserted when number==0, under the same RUN/cin/stop/clear qualifiers. down=0 behaves as the up counter. Direction may change on any cycle and takes effect on that cycle's count.
- Not defined: no `down` port; up-count only. cout is defined as in Operation.

## Structure
- Shared package watch_pkg: run-state typedef (IDLE/RUN/HOLD) with fixed 2-bit encoding, and a digit-width helper constant function. Other watch blocks reuse these.
- One natural sub-module, watch_run_ctrl: the IDLE/RUN/HOLD FSM with clear/stop/start_resume priority. It is shared with the other watch digit counters. The datapath (increment/decrement, wrap, load clamp, cout) stays in modn_digit_counter.

## Test plan
- MODULUS=10: reset low, then release, pulse start_resume, cin=1 → number 0,1,…,9,0. cout high only in the cycle number=9. running=1 from the cycle after start.
- MODULUS=6 in RUN at number=3: pulse stop → number holds 3 and running=0. Pulse start_resume → resumes 4,5,0.
- MODULUS=10, in HOLD: load with load_value=12 → number=9. Load in RUN with load_value=5 → ignored, counting continues.
- Two chained instances (MODULUS=10 and MODULUS=6), low cout→high cin: after 59 counts the pair reads 5:9. On the next count both wrap to 0:0 on the same edge, and the high cout is asserted in the 5:9 cycle.
- stop and clear together at number=7 in RUN → number=0, state IDLE, cout=0. Assert reset asynchronously mid-count → outputs 0 before the next clock edge.
- With MODN_COUNTER_DOWN_EN, MODULUS=10, down=1 from number=2 → 1,0,9. cout (borrow) is high in the number=0 cycle.

Source files
------------

// File: rtl/watch_pkg.sv
// watch_pkg: run-state encoding and digit-width helper shared by the watch digit counters.
package watch_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HOLD = 2'd2} run_state_t;
  function automatic int digit_width(input int modulus);
    return (modulus < 2) ? 1 : $clog2(modulus);
  endfunction
endpackage

// File: rtl/watch_run_ctrl.sv
// watch_run_ctrl: IDLE/RUN/HOLD control for a watch digit, priority clear > load > stop > start_resume.
module watch_run_ctrl
  import watch_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_clear,
  input  logic       i_load,
  input  logic       i_stop,
  input  logic       i_start_resume,
  output run_state_t o_state,
  output logic       o_running
);
  run_state_t r_state;
  logic       r_running;
  // a load outside RUN owns the cycle, so it also blocks a start request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_running <= 1'b0;
    end else if (i_clear || !(r_state inside {IDLE, RUN, HOLD})) begin
      r_state   <= IDLE;
      r_running <= 1'b0;
    end else if (i_stop && r_state == RUN) begin
      r_state   <= HOLD;
      r_running <= 1'b0;
    end else if (i_start_resume && !i_stop && !i_load && r_state != RUN) begin
      r_state   <= RUN;
      r_running <= 1'b1;
    end
  end
  assign o_state   = r_state;
  assign o_running = r_running;
endmodule

// File: rtl/modn_digit_counter.sv
// modn_digit_counter: modulo-MODULUS time digit with run/stop/clear control, clamped load and chained carry.
// Define MODN_COUNTER_DOWN_EN to add the down port (timer-mode decrement, cout becomes a borrow).
module modn_digit_counter
  import watch_pkg::*;
#(
  parameter int MODULUS = 10,
  parameter int WIDTH   = digit_width(MODULUS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_resume,
  input  logic             stop,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             cin,
`ifdef MODN_COUNTER_DOWN_EN
  input  logic             down,
`endif
  output logic [WIDTH-1:0] number,
  output logic             cout,
  output logic             running
);
  localparam logic [WIDTH:0] L_MAX = (WIDTH + 1)'(MODULUS - 1);
  localparam logic [WIDTH:0] L_MOD = (WIDTH + 1)'(MODULUS);
  localparam logic [WIDTH:0] L_ONE = (WIDTH + 1)'(1);
  run_state_t       w_state;
  logic [WIDTH-1:0] r_number;
  logic [WIDTH:0]   w_num, w_ld, w_next;
  logic             w_down, w_count, w_top, w_zero;
  watch_run_ctrl u_ctrl (
    .clk            (clk),
    .rst_n          (reset),
    .i_clear        (clear),
    .i_load         (load),
    .i_stop         (stop),
    .i_start_resume (start_resume),
    .o_state        (w_state),
    .o_running      (running)
  );
`ifdef MODN_COUNTER_DOWN_EN
  assign w_down = down;
`else
  assign w_down = 1'b0;
`endif
  // one spare bit keeps MODULUS == 2**WIDTH representable for compare and wrap
  assign w_num   = {1'b0, r_number};
  assign w_top   = w_num == L_MAX;
  assign w_zero  = w_num == '0;
  assign w_count = (w_state == RUN) & cin & ~stop & ~clear;
  assign w_ld    = ({1'b0, load_value} >= L_MOD) ? L_MAX : {1'b0, load_value};
  assign cout    = w_count & (w_down ? w_zero : w_top);
  always_comb
    w_next = clear ? '0 :
             (load && w_state != RUN) ? w_ld :
             !w_count ? w_num :
             w_down ? (w_zero ? L_MAX : w_num - L_ONE) :
             (w_top ? '0 : w_num + L_ONE);
  // anything past MODULUS-1 (only reachable from a corrupted value) collapses to 0
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_number <= '0;
    else r_number <= (w_next > L_MAX) ? '0 : w_next[WIDTH-1:0];
  assign number = r_number;
endmodule
